// File: rtl/hbm_read_gen_if.sv
// AXI3 read-address channel between the HBM read generator and one pseudo-channel port.
interface hbm_read_gen_if #(
  parameter int unsigned ADDR_WIDTH = 33,
  parameter int unsigned ID_WIDTH   = 6
);
  logic                  ARVALID;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [ID_WIDTH-1:0]   ARID;
  logic [3:0]            ARLEN;
  logic [2:0]            ARSIZE;
  logic [1:0]            ARBURST;
  logic                  ARREADY;

  modport master (output ARVALID, ARADDR, ARID, ARLEN, ARSIZE, ARBURST, input ARREADY);
  modport slave  (input ARVALID, ARADDR, ARID, ARLEN, ARSIZE, ARBURST, output ARREADY);
endinterface

// File: rtl/hbm_read_gen.sv
// HBM read-address generator: walks B and bit-sliced A for N epochs and issues AXI3 AR bursts
// under an outstanding-read credit limit, with abort-and-drain.
module hbm_read_gen #(
  parameter int unsigned ADDR_WIDTH        = 33,
  parameter int unsigned DATA_WIDTH        = 256,
  parameter int unsigned ID_WIDTH          = 6,
  parameter int unsigned BURST_LEN         = 4,
  parameter int unsigned MAX_OUTSTANDING   = 16,
  parameter int unsigned CHAN_SHIFT        = 28,
  parameter int unsigned FEATS_PER_CHUNK   = 64,
  parameter int unsigned BITS_PER_BURST    = 2,
  parameter int unsigned SAMPLES_PER_BLOCK = 8,
  parameter int unsigned B_PERIOD          = 8,
  parameter int unsigned A_TAG             = 1,
  parameter int unsigned B_TAG             = 0
) (
  input  logic                  hbm_clk,
  input  logic                  hbm_areset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [31:0]           number_of_epochs,
  input  logic [31:0]           number_of_samples,
  input  logic [31:0]           dimension,
  input  logic [31:0]           number_of_bits,
  input  logic [7:0]            engine_id,
  input  logic [31:0]           araddr_stride,
  hbm_read_gen_if.master        m_axi,
  input  logic                  rlast_fire,
  output logic                  busy,
  output logic                  hbm_read_done,
  output logic [7:0]            outstanding,
  output logic [31:0]           rd_addr_cnt,
  output logic [31:0]           rd_sum_cnt
);
  localparam int unsigned AW          = ADDR_WIDTH;
  localparam int unsigned CHUNK_BYTES = BURST_LEN * DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_EPOCH, ST_B_ISSUE, ST_A_ISSUE, ST_DRAIN, ST_DONE
  } state_t;

  state_t          state_q, state_d;
  logic            start_q;
  logic [31:0]     epochs_q, samples_q, dim_q, bits_q;
  logic [AW-1:0]   addr_a_q, addr_b_q, stride_q, base_a_q, base_b_q, blk_bytes_q;
  logic [7:0]      engine_q;
  logic [31:0]     chunks_q, blocks_q, planes_q;
  logic [31:0]     epoch_q, blk_q, chunk_q, plane_q, bp_cnt_q;
  logic [AW-1:0]   b_off_q, blk_off_q, chunk_off_q, plane_off_q;
  logic            arvalid_q;
  logic [AW-1:0]   araddr_q;
  logic [ID_WIDTH-1:0] arid_q;

  logic start_edge, hs, slot_free, credit_ok, rl_dec;
  logic plane_wrap, chunk_wrap, blk_last, bp_wrap;
  logic start_go, epoch_clr, issue_b, issue_a, enter_done;
  logic [31:0]   chunks_calc, blocks_calc, planes_calc;
  logic [AW-1:0] chan_base;

  assign start_edge = start & ~start_q;
  assign hs         = arvalid_q & m_axi.ARREADY;
  assign slot_free  = ~arvalid_q | m_axi.ARREADY;
  // The accepting handshake this cycle already consumes a credit.
  assign credit_ok  = (9'(outstanding) + 9'(hs)) < 9'(MAX_OUTSTANDING);
  assign rl_dec     = rlast_fire & (outstanding != 8'd0);
  assign plane_wrap = (plane_q + 32'd1) >= planes_q;
  assign chunk_wrap = (chunk_q + 32'd1) >= chunks_q;
  assign blk_last   = (blk_q + 32'd1) == blocks_q;
  assign bp_wrap    = (bp_cnt_q + 32'd1) == 32'(B_PERIOD);

  assign chunks_calc = (dim_q == 32'd0) ? 32'd1 : (dim_q - 32'd1) / 32'(FEATS_PER_CHUNK) + 32'd1;
  assign blocks_calc = (samples_q == 32'd0) ? 32'd0
                     : (samples_q - 32'd1) / 32'(SAMPLES_PER_BLOCK) + 32'd1;
  assign planes_calc = (bits_q / 32'(BITS_PER_BURST) == 32'd0) ? 32'd1 : bits_q / 32'(BITS_PER_BURST);
  assign chan_base   = AW'(engine_q) << CHAN_SHIFT;

  assign m_axi.ARVALID = arvalid_q;
  assign m_axi.ARADDR  = araddr_q;
  assign m_axi.ARID    = arid_q;
  assign m_axi.ARLEN   = 4'(BURST_LEN - 1);
  assign m_axi.ARSIZE  = 3'($clog2(DATA_WIDTH / 8));
  assign m_axi.ARBURST = 2'b01;

  always_ff @(posedge hbm_clk or posedge hbm_areset) begin
    if (hbm_areset) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next state and per-cycle action strobes.
  always_comb begin
    state_d    = state_q;
    start_go   = 1'b0;
    epoch_clr  = 1'b0;
    issue_b    = 1'b0;
    issue_a    = 1'b0;
    enter_done = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: if (start_edge) begin
        start_go = 1'b1;
        state_d  = ST_SETUP;
      end
      ST_SETUP: state_d = ST_EPOCH;
      ST_EPOCH: begin
        if (abort || epoch_q == epochs_q || blocks_q == 32'd0) state_d = ST_DRAIN;
        else begin
          epoch_clr = 1'b1;
          state_d   = ST_B_ISSUE;
        end
      end
      ST_B_ISSUE: begin
        if (abort) begin
          if (slot_free) state_d = ST_DRAIN;
        end else if (slot_free && credit_ok) begin
          issue_b = 1'b1;
          state_d = ST_A_ISSUE;
        end
      end
      ST_A_ISSUE: begin
        if (abort) begin
          if (slot_free) state_d = ST_DRAIN;
        end else if (slot_free && credit_ok) begin
          issue_a = 1'b1;
          if (plane_wrap && chunk_wrap) begin
            if (blk_last)     state_d = ST_EPOCH;
            else if (bp_wrap) state_d = ST_B_ISSUE;
          end
        end
      end
      ST_DRAIN: if (!arvalid_q && outstanding == 8'd0) begin
        enter_done = 1'b1;
        state_d    = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Configuration, walk counters and incremental address offsets.
  always_ff @(posedge hbm_clk or posedge hbm_areset) begin
    if (hbm_areset) begin
      start_q <= 1'b0;
      epochs_q <= '0; samples_q <= '0; dim_q <= '0; bits_q <= '0;
      addr_a_q <= '0; addr_b_q <= '0; stride_q <= '0; engine_q <= '0;
      base_a_q <= '0; base_b_q <= '0; blk_bytes_q <= '0;
      chunks_q <= '0; blocks_q <= '0; planes_q <= '0;
      epoch_q <= '0; blk_q <= '0; chunk_q <= '0; plane_q <= '0; bp_cnt_q <= '0;
      b_off_q <= '0; blk_off_q <= '0; chunk_off_q <= '0; plane_off_q <= '0;
    end else begin
      start_q <= start;
      if (start_go) begin
        epochs_q  <= number_of_epochs;
        samples_q <= number_of_samples;
        dim_q     <= dimension;
        bits_q    <= number_of_bits;
        addr_a_q  <= addr_a;
        addr_b_q  <= addr_b;
        stride_q  <= AW'(araddr_stride);
        engine_q  <= engine_id;
      end
      if (state_q == ST_SETUP) begin
        chunks_q    <= chunks_calc;
        blocks_q    <= blocks_calc;
        planes_q    <= planes_calc;
        blk_bytes_q <= AW'(64'(chunks_calc) * 64'(CHUNK_BYTES));
        base_a_q    <= chan_base + addr_a_q;
        base_b_q    <= chan_base + addr_b_q;
        epoch_q     <= '0;
      end
      if (epoch_clr) begin
        blk_q <= '0; chunk_q <= '0; plane_q <= '0; bp_cnt_q <= '0;
        b_off_q <= '0; blk_off_q <= '0; chunk_off_q <= '0; plane_off_q <= '0;
      end
      if (issue_b) b_off_q <= b_off_q + AW'(CHUNK_BYTES);
      if (issue_a) begin
        if (!plane_wrap) begin
          plane_q     <= plane_q + 32'd1;
          plane_off_q <= plane_off_q + stride_q;
        end else begin
          plane_q     <= '0;
          plane_off_q <= '0;
          if (!chunk_wrap) begin
            chunk_q     <= chunk_q + 32'd1;
            chunk_off_q <= chunk_off_q + AW'(CHUNK_BYTES);
          end else begin
            chunk_q     <= '0;
            chunk_off_q <= '0;
            blk_q       <= blk_q + 32'd1;
            blk_off_q   <= blk_off_q + blk_bytes_q;
            bp_cnt_q    <= bp_wrap ? 32'd0 : bp_cnt_q + 32'd1;
            if (blk_last) epoch_q <= epoch_q + 32'd1;
          end
        end
      end
    end
  end

  // AR channel registers, credit counter and run status.
  always_ff @(posedge hbm_clk or posedge hbm_areset) begin
    if (hbm_areset) begin
      arvalid_q     <= 1'b0;
      araddr_q      <= '0;
      arid_q        <= '0;
      outstanding   <= '0;
      busy          <= 1'b0;
      hbm_read_done <= 1'b0;
      rd_addr_cnt   <= '0;
      rd_sum_cnt    <= '0;
    end else begin
      if (issue_b) begin
        arvalid_q <= 1'b1;
        araddr_q  <= base_b_q + b_off_q;
        arid_q    <= ID_WIDTH'(B_TAG);
      end else if (issue_a) begin
        arvalid_q <= 1'b1;
        araddr_q  <= base_a_q + blk_off_q + chunk_off_q + plane_off_q;
        arid_q    <= ID_WIDTH'(A_TAG);
      end else if (hs) begin
        arvalid_q <= 1'b0;
      end
      if (hs && !rl_dec)      outstanding <= outstanding + 8'd1;
      else if (!hs && rl_dec) outstanding <= outstanding - 8'd1;
      if (start_go) begin
        busy          <= 1'b1;
        hbm_read_done <= 1'b0;
        rd_addr_cnt   <= '0;
        rd_sum_cnt    <= '0;
      end else begin
        if (hs)   rd_addr_cnt <= rd_addr_cnt + 32'd1;
        if (busy) rd_sum_cnt  <= rd_sum_cnt + 32'd1;
        if (enter_done) begin
          busy          <= 1'b0;
          hbm_read_done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_hbm_read_gen.sv
// Bench for hbm_read_gen: directed scenarios plus randomized configs/backpressure against a
// nested-loop reference model of the expected AR sequence.
module tb_hbm_read_gen;
  localparam int unsigned AW = 33, IW = 6, CB = 128, BP = 8, SPB = 8, FPC = 64, BPB = 2;
  localparam int unsigned A_TAG = 1, B_TAG = 0;

  logic          hbm_clk = 1'b0;
  logic          hbm_areset = 1'b1;
  logic          start = 1'b0, abort = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [31:0]   number_of_epochs = '0, number_of_samples = '0, dimension = '0, number_of_bits = '0;
  logic [7:0]    engine_id = '0;
  logic [31:0]   araddr_stride = '0;
  logic          rlast_fire = 1'b0;
  logic          arready = 1'b0;
  logic          busy, hbm_read_done;
  logic [7:0]    outstanding;
  logic [31:0]   rd_addr_cnt, rd_sum_cnt;

  int total = 0, bad = 0;
  int unsigned cyc = 0;
  int unsigned rl_q[$];
  int manual_req = 0, manual_done = 0;
  bit auto_rlast = 1'b1, rand_ready = 1'b0;
  logic arready_fix = 1'b1;
  logic [63:0] obs_q[$], exp_q[$];
  int obs_base = 0;
  bit stall_prev = 1'b0;
  logic [38:0] stall_val = '0;
  int stab_err = 0;

  hbm_read_gen_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IW)) ar_if ();
  assign ar_if.ARREADY = arready;

  hbm_read_gen dut (
    .hbm_clk(hbm_clk), .hbm_areset(hbm_areset), .start(start), .abort(abort),
    .addr_a(addr_a), .addr_b(addr_b), .number_of_epochs(number_of_epochs),
    .number_of_samples(number_of_samples), .dimension(dimension),
    .number_of_bits(number_of_bits), .engine_id(engine_id), .araddr_stride(araddr_stride),
    .m_axi(ar_if), .rlast_fire(rlast_fire), .busy(busy), .hbm_read_done(hbm_read_done),
    .outstanding(outstanding), .rd_addr_cnt(rd_addr_cnt), .rd_sum_cnt(rd_sum_cnt)
  );

  always #5 hbm_clk = ~hbm_clk;

  // Slave side: ARREADY pattern and R-channel last beats, driven just after each rising edge.
  always @(posedge hbm_clk) begin
    cyc++;
    #1;
    arready = rand_ready ? 1'($urandom_range(0, 1)) : arready_fix;
    if (rl_q.size() > 0 && rl_q[0] <= cyc + 1) begin
      rlast_fire = 1'b1;
      void'(rl_q.pop_front());
    end else if (manual_req > manual_done) begin
      rlast_fire = 1'b1;
      manual_done++;
    end else begin
      rlast_fire = 1'b0;
    end
  end

  // Handshake monitor: logs accepted ARs, schedules their last beat, tracks VALID stability.
  always @(negedge hbm_clk) begin
    if (hbm_areset) begin
      rl_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && !(ar_if.ARVALID && {ar_if.ARID, ar_if.ARADDR} == stall_val)) stab_err++;
      stall_prev = ar_if.ARVALID && !arready;
      stall_val  = {ar_if.ARID, ar_if.ARADDR};
      if (ar_if.ARVALID && arready) begin
        obs_q.push_back(64'({ar_if.ARID, ar_if.ARADDR}));
        if (auto_rlast) rl_q.push_back(cyc + 3);
      end
    end
  end

  function automatic logic [63:0] ent(input logic [IW-1:0] id, input logic [AW-1:0] a);
    return 64'({id, a});
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_cfg(input int unsigned ep, input int unsigned smp, input int unsigned dim,
                         input int unsigned bits, input logic [31:0] stride,
                         input logic [AW-1:0] aa, input logic [AW-1:0] ab, input logic [7:0] eng);
    number_of_epochs = ep; number_of_samples = smp; dimension = dim; number_of_bits = bits;
    araddr_stride = stride; addr_a = aa; addr_b = ab; engine_id = eng;
  endtask

  // Expected AR list straight from the walk definition: epochs > blocks > chunks > planes.
  task automatic build_exp();
    longint chunks, blocks, planes, blk_bytes, chan, bidx;
    exp_q.delete();
    chunks    = (dimension == 0) ? 1 : (longint'(dimension) + FPC - 1) / FPC;
    blocks    = (longint'(number_of_samples) + SPB - 1) / SPB;
    planes    = longint'(number_of_bits) / BPB;
    if (planes == 0) planes = 1;
    blk_bytes = chunks * CB;
    chan      = longint'(engine_id) << 28;
    for (longint e = 0; e < longint'(number_of_epochs); e++) begin
      bidx = 0;
      for (longint blk = 0; blk < blocks; blk++) begin
        if (blk % BP == 0) begin
          exp_q.push_back(ent(IW'(B_TAG), AW'(chan + longint'(addr_b) + bidx * CB)));
          bidx++;
        end
        for (longint ch = 0; ch < chunks; ch++)
          for (longint pl = 0; pl < planes; pl++)
            exp_q.push_back(ent(IW'(A_TAG), AW'(chan + longint'(addr_a) + blk * blk_bytes
                                               + ch * CB + pl * longint'(araddr_stride))));
      end
    end
  endtask

  task automatic begin_run();
    build_exp();
    obs_base = obs_q.size();
    stab_err = 0;
    @(posedge hbm_clk); #1 start = 1'b1;
    @(posedge hbm_clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int waited);
    waited = 0;
    while (!hbm_read_done && waited < bound) begin
      @(negedge hbm_clk);
      waited++;
    end
  endtask

  task automatic finish_run(input string tag);
    int w, n;
    wait_done(5000, w);
    check({tag, "_done"}, 64'(hbm_read_done), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_outst"}, 64'(outstanding), 64'd0);
    check({tag, "_arvalid"}, 64'(ar_if.ARVALID), 64'd0);
    check({tag, "_addr_cnt"}, 64'(rd_addr_cnt), 64'(exp_q.size()));
    check({tag, "_n_ar"}, 64'(obs_q.size() - obs_base), 64'(exp_q.size()));
    check({tag, "_stable"}, 64'(stab_err), 64'd0);
    n = obs_q.size() - obs_base;
    if (n > exp_q.size()) n = exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_ar%0d", tag, i), obs_q[obs_base + i], exp_q[i]);
  endtask

  task automatic check_s1(input string tag, input logic [AW-1:0] off);
    logic [63:0] tbl [5];
    tbl[0] = ent(6'd0, 33'h0 + off);
    tbl[1] = ent(6'd1, 33'h10000 + off);
    tbl[2] = ent(6'd1, 33'h11000 + off);
    tbl[3] = ent(6'd1, 33'h10080 + off);
    tbl[4] = ent(6'd1, 33'h11080 + off);
    for (int i = 0; i < 5; i++)
      check($sformatf("%s_tbl%0d", tag, i),
            (obs_q.size() > obs_base + i) ? obs_q[obs_base + i] : 64'hdead, tbl[i]);
  endtask

  initial begin
    int w;
    logic [38:0] v0;
    #1;
    check("rst_arvalid", 64'(ar_if.ARVALID), 64'd0);
    check("rst_araddr", 64'(ar_if.ARADDR), 64'd0);
    check("rst_arid", 64'(ar_if.ARID), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(hbm_read_done), 64'd0);
    check("rst_outst", 64'(outstanding), 64'd0);
    check("rst_cnts", 64'({rd_addr_cnt, rd_sum_cnt}), 64'd0);
    check("arlen", 64'(ar_if.ARLEN), 64'd3);
    check("arsize", 64'(ar_if.ARSIZE), 64'd5);
    check("arburst", 64'(ar_if.ARBURST), 64'd1);
    repeat (3) @(posedge hbm_clk);
    #2 hbm_areset = 1'b0;

    // Scenario 1: basic walk.
    set_cfg(1, 16, 64, 4, 32'h1000, 33'h10000, 33'h0, 8'd0);
    begin_run();
    finish_run("s1");
    check_s1("s1", 33'h0);
    check("s1_sum_nz", 64'(rd_sum_cnt > 0), 64'd1);

    // Scenario 2: channel base.
    engine_id = 8'd3;
    begin_run();
    finish_run("s2");
    check_s1("s2", 33'h3000_0000);
    engine_id = 8'd0;

    // Scenario 3: credit limit with no returns, then one return.
    set_cfg(1, 160, 64, 4, 32'h1000, 33'h10000, 33'h0, 8'd0);
    auto_rlast = 1'b0;
    begin_run();
    repeat (40) @(negedge hbm_clk);
    check("s3_cnt16", 64'(rd_addr_cnt), 64'd16);
    check("s3_out16", 64'(outstanding), 64'd16);
    check("s3_vld_lo", 64'(ar_if.ARVALID), 64'd0);
    manual_req++;
    repeat (10) @(negedge hbm_clk);
    check("s3_cnt17", 64'(rd_addr_cnt), 64'd17);
    check("s3_out16b", 64'(outstanding), 64'd16);
    check("s3_vld_lo2", 64'(ar_if.ARVALID), 64'd0);
    auto_rlast = 1'b1;
    manual_req += 16;
    finish_run("s3");

    // Scenario 4: stalled AR with abort during the stall.
    set_cfg(1, 16, 64, 4, 32'h1000, 33'h10000, 33'h0, 8'd0);
    arready_fix = 1'b0;
    begin_run();
    w = 0;
    while (!ar_if.ARVALID && w < 20) begin @(negedge hbm_clk); w++; end
    check("s4_vld_up", 64'(ar_if.ARVALID), 64'd1);
    v0 = {ar_if.ARID, ar_if.ARADDR};
    for (int i = 0; i < 10; i++) begin
      @(negedge hbm_clk);
      if (i == 2) abort = 1'b1;
      check($sformatf("s4_hold%0d", i), 64'({ar_if.ARVALID, ar_if.ARID, ar_if.ARADDR}), 64'({1'b1, v0}));
    end
    arready_fix = 1'b1;
    wait_done(200, w);
    check("s4_done", 64'(hbm_read_done), 64'd1);
    check("s4_cnt", 64'(rd_addr_cnt), 64'd1);
    check("s4_n_ar", 64'(obs_q.size() - obs_base), 64'd1);
    check("s4_outst", 64'(outstanding), 64'd0);
    check("s4_first", 64'(v0), 64'd0);
    abort = 1'b0;

    // Scenario 5: zero epochs, then two epochs.
    number_of_epochs = 0;
    begin_run();
    wait_done(50, w);
    check("s5_lat", 64'(w <= 4), 64'd1);
    finish_run("s5a");
    number_of_epochs = 2;
    begin_run();
    finish_run("s5b");
    check("s5_ep2_b", (obs_q.size() > obs_base + 5) ? obs_q[obs_base + 5] : 64'hdead, 64'd0);

    // Scenario 6: reset mid-run, then a clean rerun.
    number_of_epochs = 1;
    begin_run();
    w = 0;
    while (rd_addr_cnt < 3 && w < 50) begin @(negedge hbm_clk); w++; end
    @(posedge hbm_clk); #2 hbm_areset = 1'b1;
    #1;
    check("s6_vld", 64'(ar_if.ARVALID), 64'd0);
    check("s6_outst", 64'(outstanding), 64'd0);
    check("s6_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge hbm_clk);
    @(posedge hbm_clk); #2 hbm_areset = 1'b0;
    begin_run();
    finish_run("s6");
    check_s1("s6", 33'h0);

    // Randomized configurations under random ARREADY backpressure.
    rand_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      set_cfg($urandom_range(0, 2), $urandom_range(0, 80), $urandom_range(0, 200),
              $urandom_range(0, 3) * 2, $urandom & 32'hF_FFFF,
              {1'($urandom), 32'($urandom)}, {1'($urandom), 32'($urandom)}, 8'($urandom));
      begin_run();
      finish_run($sformatf("rnd%0d", r));
    end
    rand_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
